// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel scanner: walks rows and binary-coded-modulation bit planes, shifting pixel bits out
// of a word-addressed frame memory. Panel pins trail the memory port by one cycle.
module hub75_bcm_scanner #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned COLS    = 64,
    parameter int unsigned BPC     = 4,
    parameter int unsigned OE_BASE = 8,
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [7:0]              brightness,
    output logic [ADDR_W+COL_W-1:0] mem_addr,
    output logic                    mem_en,
    input  logic [6*BPC-1:0]        mem_data,
    output logic [ADDR_W-1:0]       addr,
    output logic [2:0]              rgb0,
    output logic [2:0]              rgb1,
    output logic                    tick,
    output logic                    latch,
    output logic                    oe,
    output logic                    frame_start
);
    localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned P_MAX   = OE_BASE << (BPC - 1);
    localparam int unsigned P_W     = $clog2(P_MAX + 1);
    localparam int unsigned SH_W    = $clog2(2 * COLS);
    localparam int unsigned CNT_W   = (P_W > SH_W) ? P_W : SH_W;
    localparam int unsigned PROD_W  = P_W + 8;

    typedef enum logic [2:0] {
        StIdle,
        StPrefetch,
        StShift,
        StLatch,
        StDisplay
    } state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       row_q;
    logic [PLANE_W-1:0]      plane_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [P_W-1:0]          on_q;
    logic                    stop_q;
    logic [ADDR_W+COL_W-1:0] mem_addr_q;
    logic                    mem_en_q;
    logic                    tick_q;
    logic                    latch_q;
    logic                    oe_q;
    logic                    frame_start_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [2:0]              rgb0_q;
    logic [2:0]              rgb1_q;

    logic [P_W-1:0]          period;
    logic [PROD_W-1:0]       prod;
    logic [P_W-1:0]          on_time;
    logic [COL_W-1:0]        col_nxt;
    logic                    rd_nxt;
    logic                    shift_done;
    logic                    disp_done;
    logic                    last_plane;
    logic                    last_row;
    logic [PLANE_W-1:0]      plane_nxt;
    logic [ADDR_W-1:0]       row_nxt;
    logic [6*BPC-1:0]        plane_bits;

    always_comb begin
        period     = P_W'(OE_BASE) << plane_q;
        prod       = PROD_W'(period) * PROD_W'(brightness);
        on_time    = P_W'(prod >> 8);
        col_nxt    = COL_W'(cnt_q >> 1) + COL_W'(1);
        rd_nxt     = !cnt_q[0] && ((cnt_q >> 1) < CNT_W'(COLS - 1));
        shift_done = cnt_q == CNT_W'(2 * COLS - 1);
        disp_done  = cnt_q == CNT_W'(period - P_W'(1));
        last_plane = plane_q == PLANE_W'(BPC - 1);
        last_row   = row_q == {ADDR_W{1'b1}};
        plane_nxt  = last_plane ? '0 : plane_q + PLANE_W'(1);
        row_nxt    = last_plane ? row_q + ADDR_W'(1) : row_q;
        // Bring the current plane's bit of every channel down to the channel's LSB position.
        plane_bits = mem_data >> plane_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            row_q         <= '0;
            plane_q       <= '0;
            cnt_q         <= '0;
            on_q          <= '0;
            stop_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_en_q      <= 1'b0;
            tick_q        <= 1'b0;
            latch_q       <= 1'b0;
            oe_q          <= 1'b1;
            frame_start_q <= 1'b0;
            addr_q        <= '0;
            rgb0_q        <= '0;
            rgb1_q        <= '0;
        end else begin
            mem_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            tick_q        <= 1'b0;
            latch_q       <= 1'b0;
            oe_q          <= 1'b1;
            if (!en && state_q != StIdle) begin
                stop_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    stop_q <= 1'b0;
                    if (en) begin
                        state_q       <= StPrefetch;
                        row_q         <= '0;
                        plane_q       <= '0;
                        mem_en_q      <= 1'b1;
                        mem_addr_q    <= '0;
                        frame_start_q <= 1'b1;
                    end
                end
                StPrefetch: begin
                    state_q <= StShift;
                    cnt_q   <= '0;
                end
                StShift: begin
                    tick_q <= cnt_q[0];
                    if (!cnt_q[0]) begin
                        rgb0_q <= {plane_bits[2*BPC], plane_bits[BPC], plane_bits[0]};
                        rgb1_q <= {plane_bits[5*BPC], plane_bits[4*BPC], plane_bits[3*BPC]};
                    end
                    if (rd_nxt) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {row_q, col_nxt};
                    end
                    if (shift_done) begin
                        state_q <= StLatch;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StLatch: begin
                    latch_q <= 1'b1;
                    addr_q  <= row_q;
                    on_q    <= on_time;
                    cnt_q   <= '0;
                    state_q <= StDisplay;
                end
                StDisplay: begin
                    oe_q  <= !(cnt_q < CNT_W'(on_q));
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (disp_done) begin
                        plane_q <= plane_nxt;
                        row_q   <= row_nxt;
                        if (stop_q || !en) begin
                            state_q <= StIdle;
                        end else begin
                            state_q       <= StPrefetch;
                            mem_en_q      <= 1'b1;
                            mem_addr_q    <= {row_nxt, COL_W'(0)};
                            frame_start_q <= last_plane && last_row;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_en      = mem_en_q;
    assign addr        = addr_q;
    assign rgb0        = rgb0_q;
    assign rgb1        = rgb1_q;
    assign tick        = tick_q;
    assign latch       = latch_q;
    assign oe          = oe_q;
    assign frame_start = frame_start_q;

endmodule
